// File: rtl/accel_pkg.sv
// Shared constants for the accelerator host: register map, opcodes, states.
// Imported by the host and by anything that models the peripheral.
package accel_pkg;

   localparam logic [3:0] ADDR_A      = 4'h0;
   localparam logic [3:0] ADDR_B      = 4'h1;
   localparam logic [3:0] ADDR_OP     = 4'h4;
   localparam logic [3:0] ADDR_RES_LO = 4'h5;
   localparam logic [3:0] ADDR_RES_HI = 4'h6;
   localparam logic [3:0] ADDR_START  = 4'h7;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;

   typedef enum logic [3:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_OP,
      WR_START,
      WAIT,
      RD_LO,
      RD_HI,
      RESP
   } state_t;

   function automatic logic is_div0(input logic [3:0] op,
                                    input logic [7:0] b);
      return (op == OP_DIV) && (b == 8'h00);
   endfunction

endpackage

// File: rtl/accel_host.sv
// Command-to-register-bus bridge: writes operands to the accelerator,
// waits, reads the 16-bit result back and returns it as a response.
module accel_host #(
   parameter int READ_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [3:0]  cmd_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic        rsp_err,
   output logic [3:0]  bus_address,
   output logic        bus_data_write,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   output logic        busy
);
   import accel_pkg::*;

   // Unused when READ_WAIT is 0 because WAIT is skipped entirely.
   localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] wait_cnt;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [3:0] op_q;
   logic       accept;
   logic       div0;

   assign accept = (state == IDLE) && cmd_valid;
   assign div0   = is_div0(cmd_op, cmd_b);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         op_q       <= 4'h0;
         rsp_result <= 16'h0000;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            a_q  <= cmd_a;
            b_q  <= cmd_b;
            op_q <= cmd_op;
            if (div0) begin
               rsp_result <= 16'hFFFF;
               rsp_err    <= 1'b1;
            end else begin
               rsp_err <= 1'b0;
            end
         end
         if (state == WR_START)
            wait_cnt <= 4'd0;
         else if (state == WAIT)
            wait_cnt <= wait_cnt + 4'd1;
         if (state == RD_LO)
            rsp_result[7:0] <= bus_rdata;
         if (state == RD_HI)
            rsp_result[15:8] <= bus_rdata;
      end
   end

   always_comb begin
      state_next     = state;
      cmd_ready      = 1'b0;
      rsp_valid      = 1'b0;
      busy           = 1'b1;
      bus_address    = 4'h0;
      bus_data_write = 1'b0;
      bus_wdata      = 8'h00;
      unique case (state)
         IDLE: begin
            busy      = 1'b0;
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_next = div0 ? RESP : WR_A;
         end
         WR_A: begin
            bus_data_write = 1'b1;
            bus_address    = ADDR_A;
            bus_wdata      = a_q;
            state_next     = WR_B;
         end
         WR_B: begin
            bus_data_write = 1'b1;
            bus_address    = ADDR_B;
            bus_wdata      = b_q;
            state_next     = WR_OP;
         end
         WR_OP: begin
            bus_data_write = 1'b1;
            bus_address    = ADDR_OP;
            bus_wdata      = {4'h0, op_q};
            state_next     = WR_START;
         end
         WR_START: begin
            bus_data_write = 1'b1;
            bus_address    = ADDR_START;
            bus_wdata      = 8'h01;
            state_next     = (READ_WAIT == 0) ? RD_LO : WAIT;
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST)
               state_next = RD_LO;
         end
         RD_LO: begin
            bus_address = ADDR_RES_LO;
            state_next  = RD_HI;
         end
         RD_HI: begin
            bus_address = ADDR_RES_HI;
            state_next  = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/accel_host.md
ACCEL_HOST -- requirements
Module: accel_host

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1: idle bus cycles between Start write and first result read; legal range 0..15.
REQ-002 SHALL have clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset: one clock, synchronous, active-low.
REQ-004 SHALL have cmd_valid  input  1, cmd_ready  output  1: command handshake.
REQ-005 SHALL have cmd_a  input  8, cmd_b  input  8, cmd_op  input  4: operands and opcode.
REQ-006 SHALL have rsp_valid  output  1, rsp_ready  input  1: response handshake.
REQ-007 SHALL have rsp_result  output  16, rsp_err  output  1: result and divide-by-zero flag.
REQ-008 SHALL have bus_address  output  4, bus_data_write  output  1, bus_wdata  output  8: register-bus initiator outputs, one write per asserted cycle.
REQ-009 SHALL have bus_rdata  input  8: combinational read data for the current bus_address.
REQ-010 SHALL have busy  output  1: high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, WR_A, WR_B, WR_OP, WR_START, WAIT, RD_LO, RD_HI, RESP.
REQ-012 SHALL drive cmd_ready high only in IDLE; a command is accepted on an edge with cmd_valid & cmd_ready, capturing cmd_a, cmd_b, cmd_op.
REQ-013 SHALL, on acceptance with cmd_op==3 and cmd_b==0, go directly to RESP with rsp_result=16'hFFFF and rsp_err=1; no bus cycles issued.
REQ-014 SHALL otherwise go to WR_A and clear rsp_err.
REQ-015 WR_A: address 0x0, data_write=1, wdata=a; WR_B: 0x1, b; WR_OP: 0x4, {4'h0,op}; WR_START: 0x7, 8'h01; each one cycle.
REQ-016 WAIT SHALL last exactly READ_WAIT cycles with data_write=0; READ_WAIT=0 skips WAIT.
REQ-017 RD_LO: address 0x5, bus_rdata latched into rsp_result[7:0] at the exiting edge; RD_HI: address 0x6, into rsp_result[15:8].
REQ-018 SHALL, outside WR_* states, drive bus_data_write=0, bus_address=0x0, bus_wdata=8'h00.
REQ-019 Nominal latency: rsp_valid first high in cycle 7+READ_WAIT after the accepting edge; div-by-zero: cycle 1.
REQ-020 rsp_valid SHALL be high only in RESP; rsp_result/rsp_err held stable while rsp_valid high.
REQ-021 RESP SHALL exit to IDLE on the edge where rsp_ready is high; rsp_ready high on RESP entry allows exit after one cycle.
REQ-022 cmd_valid in non-IDLE states SHALL be ignored (no capture, no queueing).
REQ-023 rsp_result SHALL retain its last value after RESP until overwritten by the next command.
REQ-024 Opcodes SHALL pass through unchecked; only op 3 with b==0 is special-cased.

Reset
REQ-025 On clk edge with rst_n low: state=IDLE, wait counter=0, captured operands=0, rsp_result=0, rsp_err=0.
REQ-026 Reset mid-sequence SHALL abort immediately; bus_data_write low in the cycle after the reset edge, no further writes or reads.
REQ-027 Reset values of outputs: cmd_ready=1 (after reset released), busy=0, rsp_valid=0, bus_* all 0.

Structure
REQ-028 Shared package accel_pkg SHALL hold register address constants (A=0x0, B=0x1, OP=0x4, RES_LO=0x5, RES_HI=0x6, START=0x7), opcode constants (ADD..XOR = 0..6), and the state enumeration.
REQ-029 SHALL be a single module with no sub-modules; the accelerator peripheral is instantiated only in the bench.

Verification
REQ-030 ADD: a=0x12, b=0x34, op=0, READ_WAIT=1 -> writes 0x0/0x12, 0x1/0x34, 0x4/0x00, 0x7/0x01 in consecutive cycles; rsp_result=0x0046, rsp_err=0, rsp_valid in cycle 8.
REQ-031 MUL: a=0xFF, b=0xFF, op=2 -> rsp_result=0xFE01; with READ_WAIT=0, rsp_valid in cycle 7.
REQ-032 DIV by zero: a=0x10, b=0x00, op=3 -> no bus writes, rsp_result=0xFFFF, rsp_err=1 in cycle 1; next DIV a=0x64, b=0x07 -> 0x000E, rsp_err=0.
REQ-033 Backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_result stable, cmd_ready low, cmd_valid pulses ignored; IDLE one cycle after rsp_ready rises.
REQ-034 Reset asserted during WR_OP -> next cycle busy=0, bus_data_write=0, rsp_result=0; fresh SUB a=0x05, b=0x07 then gives 0xFFFE.
